// File: rtl/mram_noc_target.sv
// mram_noc_target
// NoC responder in front of an MRAM macro model. It takes one read or write
// request at a time, holds it for the array latency (READ_LAT for reads,
// write_delay_config cycles for writes), then returns one response tagged
// with the requesting master's ID.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   write_delay_config  write busy time in cycles (0 behaves as 1), sampled at accept
//   req_*               request channel (valid/ready, write, id, addr, wdata)
//   rsp_*               response channel (valid/ready, write, id, rdata, err)
//   busy                high whenever the FSM is not in IDLE
//
// state   | meaning
// IDLE    | ready for a request
// RD_WAIT | read latency countdown (out-of-range requests also wait here, no array access)
// WR_WAIT | write busy countdown; array written on the final edge
// RESP    | response presented until rsp_ready
module mram_noc_target #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 1024,
    parameter int READ_LAT = 2,
    parameter int ID_W     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [13:0]       write_delay_config,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ID_W-1:0]   req_id,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [ID_W-1:0]   rsp_id,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RESP} state_t;

    state_t            state;
    state_t            state_next;
    logic [13:0]       cnt;
    logic [13:0]       wr_delay;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              accept;
    logic              in_range;
    logic              cnt_done;

    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign in_range  = 32'(req_addr) < DEPTH;
    assign wr_delay  = (write_delay_config == 14'd0) ? 14'd1 : write_delay_config;
    assign cnt_done  = (cnt == 14'd1);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    // Errors take one cycle in RD_WAIT so they share the 1-cycle turnaround.
                    state_next = (req_write && in_range) ? WR_WAIT : RD_WAIT;
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (cnt_done) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx_q     <= '0;
            wdata_q   <= '0;
            rsp_write <= 1'b0;
            rsp_id    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        idx_q     <= req_addr[IDX_W-1:0];
                        wdata_q   <= req_wdata;
                        rsp_write <= req_write;
                        rsp_id    <= req_id;
                        rsp_rdata <= '0;
                        rsp_err   <= !in_range;
                        if (!in_range) begin
                            cnt <= 14'd1;
                        end else if (req_write) begin
                            cnt <= wr_delay;
                        end else begin
                            cnt <= 14'(READ_LAT);
                        end
                    end
                end
                RD_WAIT: begin
                    cnt <= cnt - 14'd1;
                    if (cnt_done && !rsp_err) begin
                        rsp_rdata <= mem[idx_q];
                    end
                end
                WR_WAIT: begin
                    cnt <= cnt - 14'd1;
                end
                default: ;
            endcase
        end
    end

    // No reset on the array; a reset landing on the final write edge still aborts the write.
    always_ff @(posedge clk) begin
        if (!rst && (state == WR_WAIT) && cnt_done) begin
            mem[idx_q] <= wdata_q;
        end
    end

endmodule
